// File: rtl/sha3_byte_packer_if.sv
// Handshake bundle between a byte source, the SHA3 byte packer and the keccak core.
interface sha3_byte_packer_if;
    // byte stream from upstream
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    // word interface to the keccak core
    logic        k_reset;
    logic [63:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [2:0]  k_byte_num;
    logic        k_buffer_full;
    logic        k_out_ready;
    // status
    logic        busy;

    // master: byte source plus keccak core (everything around the packer)
    modport master (
        output s_data, s_valid, s_last, k_buffer_full, k_out_ready,
        input  s_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num, busy
    );

    // slave: the packer itself
    modport slave (
        input  s_data, s_valid, s_last, k_buffer_full, k_out_ready,
        output s_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num, busy
    );
endinterface

// File: rtl/sha3_byte_packer.sv
// Packs a byte stream big-endian into 64-bit words for the keccak core.
// Each message starts with a one-cycle core reset; a message whose length is
// a multiple of 8 is closed by an extra empty word flagged as last.
module sha3_byte_packer #(
    parameter logic [7:0] FILL = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    sha3_byte_packer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, KRST, COLLECT, SEND, SEND_LAST, TAIL, WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        tail_q, tail_d;
    logic [63:0] k_in_q, k_in_d;
    logic        k_is_last_q, k_is_last_d;
    logic [2:0]  k_byte_num_q, k_byte_num_d;
    logic        s_ready_q, s_ready_d;
    logic        k_reset_q, k_reset_d;
    logic        k_in_ready_q, k_in_ready_d;
    logic        busy_q, busy_d;

    logic        byte_xfer;
    logic        word_xfer;
    logic [5:0]  lane_hi;

    assign byte_xfer = bus.s_valid & s_ready_q;
    assign word_xfer = k_in_ready_q & ~bus.k_buffer_full;
    // top bit of the lane for byte n is 63-8n = {~n, 3'b111}
    assign lane_hi   = {~cnt_q, 3'b111};

    // State register: FSM state, byte counter, word buffer and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            tail_q       <= 1'b0;
            k_in_q       <= 64'h0;
            k_is_last_q  <= 1'b0;
            k_byte_num_q <= 3'd0;
            s_ready_q    <= 1'b0;
            k_reset_q    <= 1'b0;
            k_in_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tail_q       <= tail_d;
            k_in_q       <= k_in_d;
            k_is_last_q  <= k_is_last_d;
            k_byte_num_q <= k_byte_num_d;
            s_ready_q    <= s_ready_d;
            k_reset_q    <= k_reset_d;
            k_in_ready_q <= k_in_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Next state: message sequencing, byte counting and tail-word tracking
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tail_d  = tail_q;
        case (state_q)
            IDLE:    if (bus.s_valid) state_d = KRST;
            KRST: begin
                state_d = COLLECT;
                cnt_d   = 3'd0;
                tail_d  = 1'b0;
            end
            COLLECT: if (byte_xfer) begin
                if (!bus.s_last && cnt_q != 3'd7) begin
                    cnt_d = cnt_q + 3'd1;
                end else if (!bus.s_last) begin
                    state_d = SEND;
                end else if (cnt_q != 3'd7) begin
                    state_d = SEND_LAST;
                end else begin
                    // full final word still needs the empty closing word
                    state_d = SEND;
                    tail_d  = 1'b1;
                end
            end
            SEND: if (word_xfer) begin
                if (tail_q) begin
                    state_d = TAIL;
                end else begin
                    state_d = COLLECT;
                    cnt_d   = 3'd0;
                end
            end
            SEND_LAST: if (word_xfer) state_d = WAIT;
            TAIL:      if (word_xfer) state_d = WAIT;
            WAIT:      if (bus.k_out_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs: lane writes into the word buffer and flags decoded from the next state
    always_comb begin
        k_in_d       = k_in_q;
        k_is_last_d  = k_is_last_q;
        k_byte_num_d = k_byte_num_q;
        if (state_q == COLLECT && byte_xfer) begin
            // first byte of a word pre-fills the remaining lanes
            if (cnt_q == 3'd0) k_in_d = {bus.s_data, {7{FILL}}};
            else               k_in_d[lane_hi -: 8] = bus.s_data;
            k_is_last_d  = bus.s_last && cnt_q != 3'd7;
            k_byte_num_d = (bus.s_last && cnt_q != 3'd7) ? cnt_q + 3'd1 : 3'd0;
        end
        if (state_q == SEND && word_xfer && tail_q) begin
            k_in_d       = 64'h0;
            k_is_last_d  = 1'b1;
            k_byte_num_d = 3'd0;
        end
        s_ready_d    = (state_d == COLLECT);
        k_reset_d    = (state_d == KRST);
        k_in_ready_d = (state_d == SEND) || (state_d == SEND_LAST) || (state_d == TAIL);
        busy_d       = (state_d != IDLE);
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.k_reset    = k_reset_q;
    assign bus.k_in       = k_in_q;
    assign bus.k_in_ready = k_in_ready_q;
    assign bus.k_is_last  = k_is_last_q;
    assign bus.k_byte_num = k_byte_num_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Bench for sha3_byte_packer: a byte driver, a simple core stand-in that
// answers the last word with k_out_ready, and a word-list reference model.
module tb_sha3_byte_packer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha3_byte_packer_if bus();

    sha3_byte_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] w;
        logic        l;
        logic [2:0]  n;
    } word_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] msg_q[$];
    word_t      exp_q[$];
    word_t      got_q[$];
    bit         last_en = 1'b1;
    bit         gaps = 1'b0;
    bit         bp_force = 1'b0;
    bit         bp_rand = 1'b0;
    int         core_delay = 2;

    int         krst_cnt = 0;
    int         krst_cyc = 0;
    int         kout_cyc = 0;
    int         overlap_err = 0;
    int         stab_err = 0;
    logic       prev_kout = 1'b0;
    bit         prev_stall = 1'b0;
    logic [63:0] prev_w;
    logic        prev_l;
    logic [2:0]  prev_n;
    word_t       mon_w;

    // Monitor: sampled mid-cycle, records the word that transfers on the next rising edge
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
            prev_kout  = 1'b0;
        end else begin
            if (bus.k_in_ready && !bus.k_buffer_full) begin
                mon_w = {bus.k_in, bus.k_is_last, bus.k_is_last ? bus.k_byte_num : 3'd0};
                got_q.push_back(mon_w);
            end
            if (bus.k_reset) begin
                krst_cnt++;
                krst_cyc = cyc;
            end
            if (bus.k_out_ready && !prev_kout) kout_cyc = cyc;
            prev_kout = bus.k_out_ready;
            if (bus.s_ready && bus.k_in_ready) overlap_err++;
            if (prev_stall && (!bus.k_in_ready || bus.k_in !== prev_w ||
                               bus.k_is_last !== prev_l || bus.k_byte_num !== prev_n))
                stab_err++;
            prev_stall = bus.k_in_ready && bus.k_buffer_full;
            prev_w = bus.k_in;
            prev_l = bus.k_is_last;
            prev_n = bus.k_byte_num;
        end
    end

    // Core stand-in: some cycles after the last word, raise k_out_ready for 1..3 cycles
    initial begin
        bus.k_out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.k_in_ready && !bus.k_buffer_full && bus.k_is_last) begin
                @(posedge clk);
                repeat (core_delay - 1) @(posedge clk);
                #1 bus.k_out_ready = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1 bus.k_out_ready = 1'b0;
            end
        end
    end

    // Core backpressure: forced or random
    initial begin
        bus.k_buffer_full = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.k_buffer_full = bp_force | (bp_rand && $urandom_range(0, 2) == 0);
        end
    end

    // Reference model: message split into 8-byte big-endian words, final word
    // zero-padded with its byte count, or an empty closing word for full messages
    function automatic void build_exp();
        int n    = msg_q.size();
        int full = n / 8;
        int rem  = n % 8;
        logic [63:0] w;
        word_t e;
        exp_q.delete();
        for (int i = 0; i < full; i++) begin
            w = 64'h0;
            for (int k = 0; k < 8; k++) w = (w << 8) | 64'(msg_q[8*i+k]);
            e = {w, 1'b0, 3'd0};
            exp_q.push_back(e);
        end
        w = 64'h0;
        for (int k = 0; k < rem; k++) w = (w << 8) | 64'(msg_q[8*full+k]);
        if (rem > 0) w = w << (8 * (8 - rem));
        e = {w, 1'b1, 3'(rem)};
        exp_q.push_back(e);
    endfunction

    // Byte driver: presents msg_q, optional idle gaps with junk s_last; starts and ends at posedge+1
    task automatic drive_msg();
        int i = 0;
        int g = 0;
        int n = msg_q.size();
        bit xfer;
        while (i < n && g < 5000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'($urandom);
                bus.s_last  = 1'($urandom);
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = msg_q[i];
                bus.s_last  = last_en && (i == n - 1);
            end
            @(negedge clk);
            xfer = bus.s_valid && bus.s_ready;
            @(posedge clk);
            #1;
            g++;
            if (xfer) i++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        checks++;
        if (i < n) begin
            errors++;
            $display("FAIL drive_timeout sent %0d bytes of %0d", i, n);
        end
    endtask

    // Wait for all expected words and the return to idle
    task automatic wait_msg(input int base, input string name);
        int g = 0;
        while ((got_q.size() < base + exp_q.size() || bus.busy) && g < 3000) begin
            @(negedge clk);
            #1;
            g++;
        end
        checks++;
        if (g >= 3000) begin
            errors++;
            $display("FAIL %s_timeout words got %0d expected %0d busy %b",
                     name, got_q.size() - base, exp_q.size(), bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] ctrl;
        repeat (2) @(negedge clk);
        #1;
        ctrl = {bus.s_ready, bus.k_reset, bus.k_in_ready, bus.k_is_last, bus.k_byte_num, bus.busy};
        checks++;
        if (ctrl !== 8'h0) begin
            errors++;
            $display("FAIL reset_ctrl got %h expected 00", ctrl);
        end
        checks++;
        if (bus.k_in !== 64'h0) begin
            errors++;
            $display("FAIL reset_k_in got %h expected 0", bus.k_in);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        // s_last without s_valid must not start a message
        bus.s_last = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        ctrl = {bus.s_ready, bus.k_reset, bus.k_in_ready, bus.k_is_last, bus.k_byte_num, bus.busy};
        checks++;
        if (ctrl !== 8'h0) begin
            errors++;
            $display("FAIL idle_last_only got %h expected 00", ctrl);
        end
        bus.s_last = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fox();
        string s = "The quick brown fox jumps over the lazy dog";
        int base, kb;
        word_t gw;
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
        build_exp();
        base = got_q.size();
        kb = krst_cnt;
        gaps = 1'b0;
        drive_msg();
        wait_msg(base, "fox");
        checks++;
        if (krst_cnt - kb !== 1) begin
            errors++;
            $display("FAIL fox_krst pulses got %0d expected 1", krst_cnt - kb);
        end
        checks++;
        if (got_q.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL fox_count got %0d expected %0d", got_q.size() - base, exp_q.size());
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            gw = (base + j < got_q.size()) ? got_q[base+j] : word_t'(0);
            checks++;
            if (gw !== exp_q[j]) begin
                errors++;
                $display("FAIL fox_word%0d got %h expected %h", j, gw, exp_q[j]);
            end
        end
        gw = (base < got_q.size()) ? got_q[base] : word_t'(0);
        checks++;
        if (gw.w !== 64'h5468652071756963) begin
            errors++;
            $display("FAIL fox_first got %h expected 5468652071756963", gw.w);
        end
        gw = (got_q.size() > 0) ? got_q[got_q.size()-1] : word_t'(0);
        checks++;
        if (gw !== {64'h646f670000000000, 1'b1, 3'd3}) begin
            errors++;
            $display("FAIL fox_last got %h expected %h", gw, {64'h646f670000000000, 1'b1, 3'd3});
        end
    endtask

    task automatic test_short();
        int base, c0, g;
        word_t gw;
        msg_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        build_exp();
        base = got_q.size();
        gaps = 1'b0;
        c0 = cyc;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA1;
        bus.s_last  = 1'b0;
        g = 0;
        while (!bus.s_ready && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        checks++;
        if (cyc - c0 !== 3) begin
            errors++;
            $display("FAIL short_latency s_ready after %0d cycles expected 3", cyc - c0);
        end
        checks++;
        if (krst_cyc - c0 !== 2) begin
            errors++;
            $display("FAIL short_krst_time got %0d expected 2", krst_cyc - c0);
        end
        @(posedge clk);
        #1;
        void'(msg_q.pop_front());
        drive_msg();
        wait_msg(base, "short");
        checks++;
        if (got_q.size() - base !== 1) begin
            errors++;
            $display("FAIL short_count got %0d expected 1", got_q.size() - base);
        end
        gw = (base < got_q.size()) ? got_q[base] : word_t'(0);
        checks++;
        if (gw !== {64'hA1A2A3A4A5000000, 1'b1, 3'd5}) begin
            errors++;
            $display("FAIL short_word got %h expected %h", gw, {64'hA1A2A3A4A5000000, 1'b1, 3'd5});
        end
    endtask

    task automatic test_eight();
        int base;
        word_t gw;
        msg_q = '{8'hc2, 8'h06, 8'h34, 8'hf3, 8'h57, 8'hf4, 8'h21, 8'hfb};
        build_exp();
        base = got_q.size();
        gaps = 1'b1;
        drive_msg();
        wait_msg(base, "eight");
        checks++;
        if (got_q.size() - base !== 2) begin
            errors++;
            $display("FAIL eight_count got %0d expected 2", got_q.size() - base);
        end
        gw = (base < got_q.size()) ? got_q[base] : word_t'(0);
        checks++;
        if (gw !== {64'hc20634f357f421fb, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL eight_word0 got %h expected %h", gw, {64'hc20634f357f421fb, 1'b0, 3'd0});
        end
        gw = (base + 1 < got_q.size()) ? got_q[base+1] : word_t'(0);
        checks++;
        if (gw !== {64'h0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL eight_tail got %h expected %h", gw, {64'h0, 1'b1, 3'd0});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m2[$];
        int base, kb, kprev, g, c;
        word_t gw;
        msg_q = '{8'hc2, 8'h06, 8'h34, 8'hf3};
        for (int i = 0; i < 56; i++) msg_q.push_back(8'($urandom));
        msg_q.push_back(8'hf3); msg_q.push_back(8'h7e);
        msg_q.push_back(8'h4f); msg_q.push_back(8'h42);
        build_exp();
        base = got_q.size();
        kb = krst_cnt;
        kprev = kout_cyc;
        core_delay = 6;
        gaps = 1'b0;
        drive_msg();
        m2.delete();
        for (int i = 0; i < $urandom_range(2, 12); i++) m2.push_back(8'($urandom));
        // second message offered straight away
        bus.s_valid = 1'b1;
        bus.s_data  = m2[0];
        bus.s_last  = 1'b0;
        g = 0;
        while (!bus.s_ready && g < 500) begin
            @(negedge clk);
            #1;
            g++;
        end
        c = cyc;
        checks++;
        if (g >= 500 || kout_cyc == kprev) begin
            errors++;
            $display("FAIL b2b_wait timeout %0d new_out_ready %0d", g, kout_cyc != kprev);
        end
        checks++;
        if (krst_cyc - kout_cyc !== 2) begin
            errors++;
            $display("FAIL b2b_krst_after_out got %0d expected 2", krst_cyc - kout_cyc);
        end
        checks++;
        if (c - kout_cyc !== 3) begin
            errors++;
            $display("FAIL b2b_sready_after_out got %0d expected 3", c - kout_cyc);
        end
        checks++;
        if (krst_cnt - kb !== 2) begin
            errors++;
            $display("FAIL b2b_krst pulses got %0d expected 2", krst_cnt - kb);
        end
        checks++;
        if (got_q.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count1 got %0d expected %0d", got_q.size() - base, exp_q.size());
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            gw = (base + j < got_q.size()) ? got_q[base+j] : word_t'(0);
            checks++;
            if (gw !== exp_q[j]) begin
                errors++;
                $display("FAIL b2b_msg1_word%0d got %h expected %h", j, gw, exp_q[j]);
            end
        end
        @(posedge clk);
        #1;
        msg_q = m2;
        build_exp();
        base = got_q.size();
        void'(msg_q.pop_front());
        drive_msg();
        wait_msg(base, "b2b2");
        for (int j = 0; j < exp_q.size(); j++) begin
            gw = (base + j < got_q.size()) ? got_q[base+j] : word_t'(0);
            checks++;
            if (gw !== exp_q[j]) begin
                errors++;
                $display("FAIL b2b_msg2_word%0d got %h expected %h", j, gw, exp_q[j]);
            end
        end
        core_delay = 2;
    endtask

    task automatic test_backpressure();
        int base, sb, g, st;
        word_t gw;
        msg_q.delete();
        for (int i = 0; i < 24; i++) msg_q.push_back(8'($urandom));
        build_exp();
        base = got_q.size();
        sb = stab_err;
        gaps = 1'b0;
        fork
            drive_msg();
            begin
                g = 0;
                while (got_q.size() < base + 1 && g < 200) begin
                    @(negedge clk);
                    #1;
                    g++;
                end
                bp_force = 1'b1;
                st = 0;
                g = 0;
                while (st < 20 && g < 300) begin
                    @(negedge clk);
                    #1;
                    g++;
                    if (bus.k_in_ready && bus.k_buffer_full) st++;
                end
                checks++;
                if (st != 20) begin
                    errors++;
                    $display("FAIL bp_stall cycles got %0d expected 20", st);
                end
                checks++;
                if (bus.k_in !== exp_q[1].w || bus.s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_held k_in %h s_ready %b expected %h 0",
                             bus.k_in, bus.s_ready, exp_q[1].w);
                end
                bp_force = 1'b0;
                @(negedge clk);
                #1;
                checks++;
                if (got_q.size() - base !== 2) begin
                    errors++;
                    $display("FAIL bp_release words got %0d expected 2", got_q.size() - base);
                end
            end
        join
        wait_msg(base, "bp");
        checks++;
        if (stab_err !== sb) begin
            errors++;
            $display("FAIL bp_stable violations got %0d expected 0", stab_err - sb);
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            gw = (base + j < got_q.size()) ? got_q[base+j] : word_t'(0);
            checks++;
            if (gw !== exp_q[j]) begin
                errors++;
                $display("FAIL bp_word%0d got %h expected %h", j, gw, exp_q[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] full[$];
        logic [7:0] ctrl;
        int base, kb;
        word_t gw;
        full.delete();
        for (int i = 0; i < 20; i++) full.push_back(8'($urandom));
        msg_q = full[0:10];
        last_en = 1'b0;
        gaps = 1'b0;
        drive_msg();
        last_en = 1'b1;
        #2 reset = 1'b1;
        #1;
        ctrl = {bus.s_ready, bus.k_reset, bus.k_in_ready, bus.k_is_last, bus.k_byte_num, bus.busy};
        checks++;
        if (ctrl !== 8'h0 || bus.k_in !== 64'h0) begin
            errors++;
            $display("FAIL midreset_outputs ctrl %h k_in %h expected 0", ctrl, bus.k_in);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        msg_q = full;
        build_exp();
        base = got_q.size();
        kb = krst_cnt;
        drive_msg();
        wait_msg(base, "midreset");
        checks++;
        if (krst_cnt - kb !== 1) begin
            errors++;
            $display("FAIL midreset_krst pulses got %0d expected 1", krst_cnt - kb);
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            gw = (base + j < got_q.size()) ? got_q[base+j] : word_t'(0);
            checks++;
            if (gw !== exp_q[j]) begin
                errors++;
                $display("FAIL midreset_word%0d got %h expected %h", j, gw, exp_q[j]);
            end
        end
    endtask

    task automatic test_random();
        int base, kb;
        word_t gw;
        gaps = 1'b1;
        bp_rand = 1'b1;
        for (int m = 0; m < 10; m++) begin
            msg_q.delete();
            for (int i = 0; i < $urandom_range(1, 40); i++) msg_q.push_back(8'($urandom));
            core_delay = $urandom_range(1, 4);
            build_exp();
            base = got_q.size();
            kb = krst_cnt;
            drive_msg();
            wait_msg(base, "rand");
            checks++;
            if (krst_cnt - kb !== 1 || got_q.size() - base !== exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_shape krst %0d words %0d expected 1 %0d",
                         m, krst_cnt - kb, got_q.size() - base, exp_q.size());
            end
            for (int j = 0; j < exp_q.size(); j++) begin
                gw = (base + j < got_q.size()) ? got_q[base+j] : word_t'(0);
                checks++;
                if (gw !== exp_q[j]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d got %h expected %h", m, j, gw, exp_q[j]);
                end
            end
        end
        bp_rand = 1'b0;
        gaps = 1'b0;
    endtask

    task automatic test_invariants();
        checks++;
        if (overlap_err !== 0) begin
            errors++;
            $display("FAIL overlap s_ready with k_in_ready seen %0d times", overlap_err);
        end
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("FAIL stall_stability violations %0d", stab_err);
        end
    endtask

    initial begin
        bus.s_data  = 8'h0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        test_reset();
        test_fox();
        test_short();
        test_eight();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
